pixel_scheduler: RTL and testbench
==================================

# pixel_scheduler

Frame-level sequencer sitting directly upstream of the per-pixel depth calculator. Scans a WIDTH×HEIGHT screen in raster order. For each pixel it computes the complex constant c = (re_c, im_c) incrementally from a latched origin and step, and issues a start. It then waits for done, captures the 10-bit depth and presents it on a valid/ready pixel stream with start-of-frame and end-of-line markers for the colour-mapping/video stage.

## Interface
Parameters:
- WORD_LENGTH, 64: width of all fixed-point coordinate values (two's complement).
- FRAC, 60: fractional bits of coordinate values. Only documents the number format; no arithmetic depends on it.
- WIDTH, 640: pixels per line (≤ 2048).
- HEIGHT, 480: lines per frame (≤ 2048).

Ports:
- sysclk, in, 1: the only clock.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: level; a frame starts when sampled high in IDLE or at frame end.
- re_origin, in, WORD_LENGTH: re of pixel (0,0), the top-left corner.
- im_origin, in, WORD_LENGTH: im of pixel (0,0).
- step, in, WORD_LENGTH: pixel pitch, applied on both axes.
- calc_start, out, 1: one-cycle start pulse to the depth calculator.
- re_c, out, WORD_LENGTH: c real part; stable from calc_start until calc_done.
- im_c, out, WORD_LENGTH: c imaginary part; same stability rule.
- calc_done, in, 1: level from the calculator; high means the result is valid.
- calc_depth, in, 10: calculator result.
- pix_depth, out, 10: depth of the current output pixel.
- pix_valid, out, 1: output pixel available.
- pix_ready, in, 1: downstream accepts.
- pix_sof, out, 1: qualifies pix_valid; marks pixel (0,0).
- pix_eol, out, 1: qualifies pix_valid; marks x = WIDTH-1.
- x, out, 11: column of the current pixel.
- y, out, 11: row of the current pixel.
- frame_done, out, 1: one-cycle pulse after the last pixel's handshake.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, OUTPUT.
- IDLE: all strobes low.
  - enable=1 → LOAD.
- LOAD (1 cycle):
  - Latch re_origin, im_origin and step into internal registers. Input changes mid-frame have no effect.
  - Set x=0, y=0, re_c=re_origin, im_c=im_origin.
  - → ISSUE.
- ISSUE (1 cycle): calc_start=1 → WAIT.
- WAIT: calc_done is ignored in every other state.
  - On calc_done=1: register pix_depth=calc_depth.
  - → OUTPUT.
- OUTPUT: pix_valid=1; pix_depth, pix_sof, pix_eol, x and y are held stable until pix_valid & pix_ready.
- On handshake, coordinate update:
  - x<WIDTH-1: x+1, re_c += step, y and im_c unchanged.
  - x=WIDTH-1, y<HEIGHT-1: x=0, y+1, re_c=latched re_origin, im_c -= step.
- Transitions on handshake:
  - Not the last pixel → ISSUE.
  - Last pixel (x=WIDTH-1, y=HEIGHT-1) → frame_done=1 next cycle. Then → LOAD if enable=1, else IDLE.
- Arithmetic: WORD_LENGTH-bit two's-complement add/sub, modular wrap, no saturation, no multipliers.
- pix_sof = (x==0 && y==0); pix_eol = (x==WIDTH-1); both registered alongside pix_valid.
- enable low mid-frame does not abort; the frame completes.
- Only one calculation is ever outstanding.

## Timing
- Reset (synchronous):
  - State IDLE.
  - calc_start, pix_valid, pix_sof, pix_eol and frame_done are 0.
  - pix_depth, x, y, re_c and im_c are 0.
  - Latched origin/step are 0.
  - Applies from the first edge with reset=1, including mid-WAIT and mid-OUTPUT. Any in-flight result is discarded.
- enable sampled high in IDLE at edge N → LOAD at N+1 → calc_start high during cycle N+2.
- calc_done sampled high at edge M → pix_valid high from M+1 (1-cycle capture latency).
- Handshake at edge K:
  - Not the last pixel: next calc_start high in cycle K+1 with the updated re_c/im_c already stable.
  - Last pixel: frame_done high in cycle K+1.
- Fixed overhead per pixel beyond calculator latency and backpressure: 3 cycles (ISSUE, capture, handshake).
- calc_done already high when entering WAIT is accepted. The calculator clears done on the start edge, so this does not occur in normal operation.
- pix_ready high while pix_valid is low has no effect.

## Test plan
- Bench config: WIDTH=4, HEIGHT=3, FRAC=60, calculator model with a fixed latency of 5 cycles.
- Reset: hold reset 3 cycles with enable=1 → all outputs 0, no calc_start until 2 cycles after reset falls.
- Raster scan: re_origin=-2.0, im_origin=+1.0, step=0.25 (Q4.60), pix_ready=1 → 12 pixels in order (0,0)…(3,2).
  - re_c for x=3 is -1.25; im_c for y=2 is +0.5.
  - pix_sof on pixel 0 only; pix_eol on pixels 3, 7 and 11; one frame_done pulse.
- Depth capture: model returns depth = 10·y + x → pix_depth stream is 0, 1, 2, 3, 10, 11, 12, 13, 20, 21, 22, 23. The model holds done high after each result; no duplicate pixels appear.
- Backpressure: pix_ready low for 7 cycles on pixel 5 → pix_depth, x, y and pix_eol stay stable; no calc_start during the stall; the next calc_start comes 1 cycle after the handshake.
- Mid-frame changes:
  - re_origin changed after pixel 2 → remaining pixels use the latched value.
  - enable dropped at pixel 6 → frame completes, then IDLE.
  - enable held high → the next frame's calc_start follows frame_done by 2 cycles.
- Reset mid-WAIT with calc_done arriving 1 cycle later → no pix_valid; state IDLE; a restart begins at pixel (0,0).

Source files
------------

// File: rtl/pixel_scheduler.sv
// pixel_scheduler
// Raster-order frame sequencer for the per-pixel depth calculator.
// Each pixel goes through issue -> wait -> output. c = (re_c, im_c) is
// stepped with adds and subtracts from an origin and step latched at
// frame start. Depths are presented on a valid/ready stream with
// start-of-frame and end-of-line markers.
module pixel_scheduler #(
  parameter int WORD_LENGTH = 64,
  parameter int FRAC        = 60,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WORD_LENGTH-1:0] re_origin,
  input  logic [WORD_LENGTH-1:0] im_origin,
  input  logic [WORD_LENGTH-1:0] step,
  output logic                   calc_start,
  output logic [WORD_LENGTH-1:0] re_c,
  output logic [WORD_LENGTH-1:0] im_c,
  input  logic                   calc_done,
  input  logic [9:0]             calc_depth,
  output logic [9:0]             pix_depth,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_sof,
  output logic                   pix_eol,
  output logic [10:0]            x,
  output logic [10:0]            y,
  output logic                   frame_done
);

  localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);

  // FRAC only names the number format; reject parameter sets the
  // 11-bit counters or the word width cannot represent.
  generate
    if (FRAC >= WORD_LENGTH || WIDTH < 1 || WIDTH > 2048 ||
        HEIGHT < 1 || HEIGHT > 2048) begin : g_bad_cfg
      $error("pixel_scheduler: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t                 state_reg;
  logic [WORD_LENGTH-1:0] re_org_reg;
  logic [WORD_LENGTH-1:0] im_org_reg;
  logic [WORD_LENGTH-1:0] step_reg;
  logic [WORD_LENGTH-1:0] re_c_reg;
  logic [WORD_LENGTH-1:0] im_c_reg;
  logic [10:0]            x_reg;
  logic [10:0]            y_reg;
  logic [9:0]             depth_reg;
  logic                   start_reg;
  logic                   valid_reg;
  logic                   sof_reg;
  logic                   eol_reg;
  logic                   done_reg;

  // Frame sequencer: state, coordinate stepping and all registered outputs.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      re_org_reg <= '0;
      im_org_reg <= '0;
      step_reg   <= '0;
      re_c_reg   <= '0;
      im_c_reg   <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      depth_reg  <= '0;
      start_reg  <= 1'b0;
      valid_reg  <= 1'b0;
      sof_reg    <= 1'b0;
      eol_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      start_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (enable) begin
            state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Inputs are sampled once here so mid-frame changes are ignored.
          re_org_reg <= re_origin;
          im_org_reg <= im_origin;
          step_reg   <= step;
          re_c_reg   <= re_origin;
          im_c_reg   <= im_origin;
          x_reg      <= '0;
          y_reg      <= '0;
          start_reg  <= 1'b1;
          state_reg  <= S_ISSUE;
        end
        S_ISSUE: begin
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (calc_done) begin
            depth_reg <= calc_depth;
            valid_reg <= 1'b1;
            sof_reg   <= (x_reg == 11'd0) && (y_reg == 11'd0);
            eol_reg   <= (x_reg == X_LAST);
            state_reg <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (valid_reg && pix_ready) begin
            valid_reg <= 1'b0;
            sof_reg   <= 1'b0;
            eol_reg   <= 1'b0;
            if (x_reg == X_LAST && y_reg == Y_LAST) begin
              // IDLE re-samples enable, so back-to-back frames restart from there.
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              if (x_reg != X_LAST) begin
                x_reg    <= x_reg + 11'd1;
                re_c_reg <= re_c_reg + step_reg;
              end else begin
                x_reg    <= '0;
                y_reg    <= y_reg + 11'd1;
                re_c_reg <= re_org_reg;
                im_c_reg <= im_c_reg - step_reg;
              end
              start_reg <= 1'b1;
              state_reg <= S_ISSUE;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign calc_start = start_reg;
  assign re_c       = re_c_reg;
  assign im_c       = im_c_reg;
  assign pix_depth  = depth_reg;
  assign pix_valid  = valid_reg;
  assign pix_sof    = sof_reg;
  assign pix_eol    = eol_reg;
  assign x          = x_reg;
  assign y          = y_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler
// Randomised bench for pixel_scheduler on a 4x3 screen. A fixed-latency
// calculator model answers each start. The reference computes every pixel's
// c as origin + x*step / origin - y*step from the pixel index. It also
// predicts the start and frame_done cycles from the handshake history.
module tb_pixel_scheduler;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] re_origin = '0;
  logic [63:0] im_origin = '0;
  logic [63:0] step      = '0;
  logic        calc_start;
  logic [63:0] re_c;
  logic [63:0] im_c;
  logic        calc_done  = 1'b0;
  logic [9:0]  calc_depth = '0;
  logic [9:0]  pix_depth;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_sof;
  logic        pix_eol;
  logic [10:0] x;
  logic [10:0] y;
  logic        frame_done;

  pixel_scheduler #(
    .WORD_LENGTH(64),
    .FRAC       (60),
    .WIDTH      (W),
    .HEIGHT     (H)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .enable    (enable),
    .re_origin (re_origin),
    .im_origin (im_origin),
    .step      (step),
    .calc_start(calc_start),
    .re_c      (re_c),
    .im_c      (im_c),
    .calc_done (calc_done),
    .calc_depth(calc_depth),
    .pix_depth (pix_depth),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .x         (x),
    .y         (y),
    .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  // Calculator model: fixed 5-cycle latency, done cleared by start, held afterwards.
  int         calc_cnt = 0;
  logic [9:0] calc_pend = '0;
  always @(posedge sysclk) begin
    if (calc_start) begin
      calc_done <= 1'b0;
      calc_cnt  <= 5;
      calc_pend <= 10'(10 * int'(y) + int'(x));
    end else if (calc_cnt > 0) begin
      calc_cnt <= calc_cnt - 1;
      if (calc_cnt == 1) begin
        calc_done  <= 1'b1;
        calc_depth <= calc_pend;
      end
    end
  end

  // Reference state
  logic [63:0] m_re = '0, m_im = '0, m_step = '0;
  int   pix_idx       = 0;
  int   frames_seen   = 0;
  int   exp_start_cyc = -1;
  int   exp_fd_cyc    = -1;
  bit   load_pending  = 1'b0;
  bit   have_prev     = 1'b0;
  bit   prev_valid    = 1'b0;
  bit   prev_ready    = 1'b0;
  logic [33:0] prev_snap = '0;

  function automatic logic [63:0] exp_re(input int idx);
    return m_re + 64'(idx % W) * m_step;
  endfunction

  function automatic logic [63:0] exp_im(input int idx);
    return m_im - 64'(idx / W) * m_step;
  endfunction

  // Monitor: samples on the falling edge and checks against the reference.
  always @(negedge sysclk) begin
    if (reset) begin
      pix_idx   = 0;
      have_prev = 1'b0;
    end else begin
      if (load_pending && cyc == exp_start_cyc - 1) begin
        m_re   = re_origin;
        m_im   = im_origin;
        m_step = step;
        load_pending = 1'b0;
      end
      if (calc_start || cyc == exp_start_cyc) begin
        check("start_cycle", calc_start ? 64'(cyc) : 64'd0, 64'(exp_start_cyc));
        if (calc_start) begin
          check("start_re_c", re_c, exp_re(pix_idx));
          check("start_im_c", im_c, exp_im(pix_idx));
          if (frames_seen == 0 && pix_idx == 3) check("re_c_x3", re_c, 64'hEC00_0000_0000_0000);
          if (frames_seen == 0 && pix_idx == 8) check("im_c_y2", im_c, 64'h0800_0000_0000_0000);
        end
        exp_start_cyc = -1;
      end
      if (frame_done || cyc == exp_fd_cyc) begin
        check("frame_done_cycle", frame_done ? 64'(cyc) : 64'd0, 64'(exp_fd_cyc));
        exp_fd_cyc = -1;
        if (frame_done) begin
          frames_seen++;
          $display("frame %0d done at cycle %0d", frames_seen, cyc);
          if (enable) begin
            exp_start_cyc = cyc + 2;
            load_pending  = 1'b1;
          end
        end
      end
      if (pix_valid && have_prev && prev_valid && !prev_ready)
        check("hold", 64'({x, y, pix_depth, pix_eol, pix_sof}), 64'(prev_snap));
      if (pix_valid && pix_ready) begin
        $display("pixel f=%0d i=%0d (x=%0d,y=%0d) depth=%0d sof=%0b eol=%0b",
                 frames_seen, pix_idx, x, y, pix_depth, pix_sof, pix_eol);
        check("x", 64'(x), 64'(pix_idx % W));
        check("y", 64'(y), 64'(pix_idx / W));
        check("depth", 64'(pix_depth), 64'(10 * (pix_idx / W) + pix_idx % W));
        check("sof", 64'(pix_sof), 64'(pix_idx == 0));
        check("eol", 64'(pix_eol), 64'(pix_idx % W == W - 1));
        check("hs_re_c", re_c, exp_re(pix_idx));
        pix_idx++;
        if (pix_idx == NPIX) begin
          pix_idx    = 0;
          exp_fd_cyc = cyc + 1;
        end else begin
          exp_start_cyc = cyc + 1;
        end
      end
      have_prev  = 1'b1;
      prev_valid = pix_valid;
      prev_ready = pix_ready;
      prev_snap  = {x, y, pix_depth, pix_eol, pix_sof};
    end
  end

  // Downstream ready and mid-frame input scrambling, driven just after the edge.
  bit force_low   = 1'b0;
  bit rand_ready  = 1'b0;
  bit rand_inputs = 1'b0;
  initial begin
    forever begin
      @(posedge sysclk);
      #1;
      if (force_low) pix_ready = 1'b0;
      else if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
      else pix_ready = 1'b1;
      if (rand_inputs && (cyc % 9 == 0)) begin
        re_origin = {$urandom, $urandom};
        im_origin = {$urandom, $urandom};
        step      = {$urandom, $urandom};
      end
    end
  end

  // Watchdog
  always @(posedge sysclk) begin
    if (cyc > 30000) begin
      miscompares++;
      $display("FAIL watchdog: got cycle %0d expected completion before 30000", cyc);
      summary();
      $finish;
    end
  end

  task automatic wait_pix(input int t_idx, input int t_frames, input string tag);
    int budget = 3000;
    while (!(pix_idx == t_idx && frames_seen == t_frames) && budget > 0) begin
      @(negedge sysclk);
      budget--;
    end
    if (budget == 0) check(tag, 64'(frames_seen * 100 + pix_idx), 64'(t_frames * 100 + t_idx));
  endtask

  task automatic start_frame();
    @(posedge sysclk);
    #1;
    enable        = 1'b1;
    exp_start_cyc = cyc + 2;
    load_pending  = 1'b1;
  endtask

  initial begin
    int budget;
    enable    = 1'b1;
    re_origin = 64'hE000_0000_0000_0000;  // -2.0
    im_origin = 64'h1000_0000_0000_0000;  // +1.0
    step      = 64'h0400_0000_0000_0000;  // 0.25
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      check("rst_strobes", 64'({calc_start, pix_valid, pix_sof, pix_eol, frame_done}), 64'd0);
      check("rst_data", 64'({pix_depth, x, y}), 64'd0);
      check("rst_re_c", re_c, 64'd0);
      check("rst_im_c", im_c, 64'd0);
    end
    reset         = 1'b0;
    exp_start_cyc = cyc + 2;
    load_pending  = 1'b1;

    // Frame 0 plain raster; frame 1 chains with backpressure and mid-frame changes.
    wait_pix(3, 1, "wait_f1_p3");
    re_origin = {$urandom, $urandom};
    wait_pix(5, 1, "wait_f1_p5");
    force_low = 1'b1;
    budget = 100;
    while (!pix_valid && budget > 0) begin
      @(negedge sysclk);
      budget--;
    end
    if (budget == 0) check("wait_stall_valid", 64'(pix_valid), 64'd1);
    repeat (6) @(negedge sysclk);
    force_low = 1'b0;
    wait_pix(6, 1, "wait_f1_p6");
    enable = 1'b0;
    wait_pix(0, 2, "wait_f1_end");
    repeat (20) @(negedge sysclk);
    check("idle_quiet", 64'({pix_valid, calc_start, frame_done}), 64'd0);

    // Randomised frames with random origin/step and random backpressure.
    rand_inputs = 1'b1;
    rand_ready  = 1'b1;
    start_frame();
    wait_pix(3, 5, "wait_rand_last");
    enable = 1'b0;
    wait_pix(0, 6, "wait_rand_end");
    rand_inputs = 1'b0;
    rand_ready  = 1'b0;

    // Reset while waiting on the calculator; the result lands after reset.
    start_frame();
    wait_pix(2, 6, "wait_rst_p2");
    budget = 100;
    while (calc_cnt != 2 && budget > 0) begin
      @(negedge sysclk);
      budget--;
    end
    if (budget == 0) check("wait_calc_cnt", 64'(calc_cnt), 64'd2);
    reset         = 1'b1;
    enable        = 1'b0;
    exp_start_cyc = -1;
    exp_fd_cyc    = -1;
    load_pending  = 1'b0;
    @(negedge sysclk);
    reset = 1'b0;
    check("mid_rst_coords", 64'({x, y}), 64'd0);
    check("mid_rst_re_c", re_c, 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclk);
      check("mid_rst_no_valid", 64'({pix_valid, calc_start}), 64'd0);
    end

    // Restart must begin again at pixel (0,0).
    start_frame();
    wait_pix(6, 6, "wait_restart_p6");
    enable = 1'b0;
    wait_pix(0, 7, "wait_restart_end");
    repeat (5) @(negedge sysclk);
    check("final_quiet", 64'({pix_valid, calc_start, frame_done}), 64'd0);
    check("frames_total", 64'(frames_seen), 64'd7);
    summary();
    $finish;
  end

endmodule
